// File: rtl/uart_rx_keypad.sv
// 8N1 UART receiver (LSB first) with framing-error detection and keypad ASCII
// to 4-bit key-code mapping for remote key presses.
module uart_rx_keypad #(
  parameter int DELAY_FRAMES    = 2812,
  parameter int HALF_DELAY_WAIT = DELAY_FRAMES / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  localparam logic [11:0] BIT_LAST  = 12'(DELAY_FRAMES - 1);
  localparam logic [11:0] HALF_LAST = 12'(HALF_DELAY_WAIT - 1);

  logic [2:0]  state;
  logic        rx_meta;
  logic        rx_s;
  logic [11:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        map_hit;
  logic [3:0]  map_code;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Shift register is complete by the time STOP samples, so the map is stable then.
  always_comb begin
    map_hit  = 1'b0;
    map_code = 4'h0;
    if (shift >= 8'h30 && shift <= 8'h39) begin
      map_hit  = 1'b1;
      map_code = shift[3:0];
    end else if (shift >= 8'h41 && shift <= 8'h44) begin
      map_hit  = 1'b1;
      map_code = shift[3:0] + 4'h9;
    end else if (shift == 8'h2A) begin
      map_hit  = 1'b1;
      map_code = 4'hF;
    end else if (shift == 8'h23) begin
      map_hit  = 1'b1;
      map_code = 4'hE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 12'd0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      data       <= 8'h00;
      key_code   <= 4'h0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      key_valid  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      key_valid  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 12'd0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= 12'd0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= 12'd0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets an immediately following start bit be seen.
          if (cnt == BIT_LAST) begin
            cnt <= 12'd0;
            if (rx_s) begin
              state      <= IDLE;
              data       <= shift;
              data_valid <= 1'b1;
              if (map_hit) begin
                key_code  <= map_code;
                key_valid <= 1'b1;
              end
            end else begin
              state     <= BRK;
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        BRK: begin
          cnt <= 12'd0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 12'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_keypad.sv
// Scoreboarded random bench for uart_rx_keypad with a shortened bit period;
// expected frames come from a byte-level model of the receive and key rules.
module tb_uart_rx_keypad;

  localparam int D   = 32;
  localparam int H   = D / 2;
  localparam int LAT = 2 + H + 9 * D + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic [3:0] key_code;
  logic       key_valid;
  logic       busy;

  uart_rx_keypad #(.DELAY_FRAMES(D), .HALF_DELAY_WAIT(H)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .data(data), .data_valid(data_valid),
    .frame_err(frame_err), .key_code(key_code), .key_valid(key_valid), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // entry = {frame_err, data, key_valid, key_code}
  logic [13:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int t_start  = 0;
  int kv_count = 0;
  logic [7:0] m_data = 8'h00;
  logic [3:0] m_key  = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic is_key(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h44) ||
           b == 8'h2A || b == 8'h23;
  endfunction

  function automatic logic [3:0] key_of(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return 4'(int'(b) - 'h30);
    if (b >= 8'h41 && b <= 8'h44) return 4'(int'(b) - 'h41 + 10);
    if (b == 8'h2A) return 4'hF;
    return 4'hE;
  endfunction

  task automatic expect_frame(input logic [7:0] b, input logic stop_ok);
    logic kv;
    if (stop_ok) begin
      kv = is_key(b);
      if (kv) m_key = key_of(b);
      m_data = b;
      exp_q.push_back({1'b0, b, kv, m_key});
    end else begin
      exp_q.push_back({1'b1, m_data, 1'b0, m_key});
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at a negedge with the line high.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int hold_low);
    expect_frame(b, stop_ok);
    uart_rx = 1'b0;
    t_start = cyc;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (D) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (D) @(negedge clk);
    if (!stop_ok) begin
      if (hold_low > 0) begin
        repeat (hold_low) @(negedge clk);
        check("break_busy", busy, 1);
      end
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain;
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20 * D) begin
      @(negedge clk);
      k++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [13:0] e;
    int lat;
    forever begin
      @(negedge clk);
      if (key_valid) begin
        kv_count++;
        check("key_valid_with_data_valid", data_valid, 1);
      end
      if (data_valid) check("data_valid_frame_err_exclusive", frame_err, 0);
      if (data_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {frame_err, data, key_valid, key_code}, 0);
        end else begin
          e = exp_q.pop_front();
          check("frame", {frame_err, data, key_valid, key_code}, e);
          lat = cyc - t_start;
          checks++;
          if (lat < LAT - 1 || lat > LAT + 1) begin
            failures++;
            $display("FAIL latency actual=%0d required=%0d+-1", lat, LAT);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] keys [16];
    int kv_before;
    logic [7:0] b;
    logic ok;
    keys = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
             8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h2A, 8'h23};

    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", data, 8'h00);
    check("reset_key_code", key_code, 4'h0);
    check("reset_pulses", {data_valid, frame_err, key_valid}, 3'b000);
    check("reset_busy", busy, 0);
    rst = 1'b1;

    idle(2000);
    check("idle_data", data, 8'h00);
    check("idle_key_code", key_code, 4'h0);
    check("idle_busy", busy, 0);

    send_byte(8'h35, 1'b1, 0);
    drain();
    check("five_data", data, 8'h35);
    check("five_key", key_code, 4'h5);
    check("five_busy", busy, 0);

    kv_before = kv_count;
    send_byte(8'h2A, 1'b1, 0);
    send_byte(8'h23, 1'b1, 0);
    drain();
    check("star_hash_key", key_code, 4'hE);
    check("star_hash_kv_pulses", kv_count - kv_before, 2);

    send_byte(8'h32, 1'b0, 5000 / (2812 / D));
    drain();
    check("frame_err_data_kept", data, 8'h23);
    check("after_break_busy", busy, 0);
    idle(10);
    send_byte(8'h41, 1'b1, 0);
    drain();
    check("after_break_key_a", key_code, 4'hA);

    uart_rx = 1'b0;
    repeat (H / 2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * D) @(negedge clk);
    check("glitch_busy", busy, 0);
    check("glitch_no_pulse_queue", exp_q.size(), 0);
    send_byte(8'h7A, 1'b1, 0);
    drain();
    check("z_data", data, 8'h7A);
    check("z_key_unchanged", key_code, 4'hA);

    // abort mid-bit-4, then a clean frame
    uart_rx = 1'b0;
    repeat (D) @(negedge clk);
    b = 8'h55;
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      repeat (D) @(negedge clk);
    end
    uart_rx = b[4];
    repeat (H) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_data_cleared", data, 8'h00);
    uart_rx = 1'b1;
    m_data = 8'h00;
    m_key  = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4 * D) @(negedge clk);
    check("abort_idle_busy", busy, 0);
    send_byte(8'h39, 1'b1, 0);
    drain();
    check("nine_data", data, 8'h39);
    check("nine_key", key_code, 4'h9);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 0) b = keys[$urandom_range(0, 15)];
      else b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 9) != 0);
      send_byte(b, ok, ok ? 0 : $urandom_range(0, 100));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 40));
    end
    drain();
    check("final_data", data, m_data);
    check("final_key", key_code, m_key);
    check("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
